// File: rtl/spu_decode_pkg.sv
// spu_decode_pkg
// Shared definitions for the registered SPU decode stage:
//   - state_t        : sequencer states (IDLE / HOLD / BURST)
//   - OP_*           : instruction class encodings of the Op field
//   - FN_* / ALU_*   : data-processing funct[4:1] codes and ALUControl values
//   - FN_DRW_*       : SPU funct[4:1] codes that select a DRW (draw) instruction
//   - ctrl_t         : fixed-width part of the control bundle
//                      (the SPU control word is COLOR_W dependent and kept apart)
//   - alu_map/alu_known : data-processing funct -> ALUControl lookup
package spu_decode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_BURST = 2'b10
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_SPU = 2'b11;

    localparam logic [3:0] FN_AND = 4'b0000;
    localparam logic [3:0] FN_EOR = 4'b0001;
    localparam logic [3:0] FN_SUB = 4'b0010;
    localparam logic [3:0] FN_ADD = 4'b0100;
    localparam logic [3:0] FN_LSL = 4'b1000;
    localparam logic [3:0] FN_LSR = 4'b1001;
    localparam logic [3:0] FN_CMP = 4'b1010;
    localparam logic [3:0] FN_ORR = 4'b1100;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_EOR = 4'b0100;
    localparam logic [3:0] ALU_LSL = 4'b1000;
    localparam logic [3:0] ALU_LSR = 4'b1001;

    localparam logic [3:0] FN_DRW_A = 4'b0101;
    localparam logic [3:0] FN_DRW_B = 4'b1100;

    typedef struct packed {
        logic [1:0] flagw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       regw_spu;
        logic       nowrite;
        logic       memtoreg;
        logic       alusrc;
        logic [1:0] immsrc;
        logic [1:0] regsrc;
        logic [3:0] alucontrol;
    } ctrl_t;

    // Unmapped codes fall back to ADD.
    function automatic logic [3:0] alu_map(input logic [3:0] fn);
        case (fn)
            FN_AND:  return ALU_AND;
            FN_EOR:  return ALU_EOR;
            FN_SUB:  return ALU_SUB;
            FN_ADD:  return ALU_ADD;
            FN_LSL:  return ALU_LSL;
            FN_LSR:  return ALU_LSR;
            FN_CMP:  return ALU_SUB;
            FN_ORR:  return ALU_ORR;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic alu_known(input logic [3:0] fn);
        return fn inside {FN_AND, FN_EOR, FN_SUB, FN_ADD,
                          FN_LSL, FN_LSR, FN_CMP, FN_ORR};
    endfunction

endpackage

// File: rtl/spu_decode_comb.sv
// spu_decode_comb
// Pure combinational decode of {op, funct, rd, color} into the control bundle.
// Ports:
//   op, funct, rd, color : instruction fields
//   ctrl                 : fixed-width control bundle (ctrl_t)
//   spucontrol           : SPU control word {funct[4:1], color}, all-ones for non-SPU
//   is_drw               : instruction is an SPU draw (multi-beat at the stage)
//   illegal              : only with SPU_DECODE_ILLEGAL_TRAP_EN; encoding is trapped
// Configuration macro: SPU_DECODE_ILLEGAL_TRAP_EN
module spu_decode_comb
    import spu_decode_pkg::*;
#(
    parameter int COLOR_W = 8
) (
    input  logic [1:0]         op,
    input  logic [5:0]         funct,
    input  logic [3:0]         rd,
    input  logic [COLOR_W-1:0] color,
`ifdef SPU_DECODE_ILLEGAL_TRAP_EN
    output logic               illegal,
`endif
    output ctrl_t              ctrl,
    output logic [COLOR_W+3:0] spucontrol,
    output logic               is_drw
);

    logic [3:0] fn;
    assign fn = funct[4:1];

    always_comb begin
        ctrl       = '0;
        spucontrol = '1;
        is_drw     = 1'b0;
`ifdef SPU_DECODE_ILLEGAL_TRAP_EN
        illegal    = 1'b0;
`endif
        case (op)
            OP_DP: begin
                ctrl.regw       = 1'b1;
                ctrl.alusrc     = funct[5];
                ctrl.alucontrol = alu_map(fn);
                ctrl.nowrite    = (fn == FN_CMP);
                ctrl.flagw[1]   = funct[0];
                ctrl.flagw[0]   = funct[0] & ((fn == FN_ADD) | (fn == FN_SUB) | (fn == FN_CMP));
            end
            OP_MEM: begin
                ctrl.immsrc   = 2'b01;
                ctrl.alusrc   = 1'b1;
                ctrl.memtoreg = 1'b1;
                if (funct[0]) begin
                    ctrl.regw = 1'b1;          // LDR
                end else begin
                    ctrl.regsrc = 2'b10;       // STR reads Rd as store data
                    ctrl.memw   = 1'b1;
                end
            end
            OP_BR: begin
                ctrl.regsrc = 2'b01;
                ctrl.immsrc = 2'b10;
                ctrl.alusrc = 1'b1;
            end
            default: begin                     // OP_SPU
                spucontrol    = {fn, color};
                ctrl.memtoreg = 1'b1;
                if ((fn == FN_DRW_A) || (fn == FN_DRW_B)) begin
                    is_drw    = 1'b1;
                    ctrl.memw = 1'b1;          // draw writes the frame buffer
                end else begin
                    ctrl.regw     = 1'b1;
                    ctrl.regw_spu = 1'b1;
                end
            end
        endcase

        // Writing r15 redirects the PC just like a branch.
        ctrl.pcs = (op == OP_BR) | ((rd == 4'hF) & ctrl.regw);

`ifdef SPU_DECODE_ILLEGAL_TRAP_EN
        illegal = ((op == OP_DP) & ~alu_known(fn)) | ((op == OP_SPU) & funct[0]);
        if (illegal) begin
            // Trapped encodings become a harmless single-beat NOP.
            ctrl.regw     = 1'b0;
            ctrl.memw     = 1'b0;
            ctrl.regw_spu = 1'b0;
            ctrl.pcs      = 1'b0;
            is_drw        = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/spu_decode_stage.sv
// spu_decode_stage
// Registered decode stage between fetch and register-read/execute. Decodes each
// accepted instruction into a registered control bundle; an SPU draw (DRW)
// is replayed as DRW_BEATS consecutive beats with an incrementing beat index.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : fetch-side handshake
//   in_op/funct/rd/color : instruction fields
//   flush                : taken branch; kills the held and the incoming instruction
//   out_valid / out_ready: execute-side handshake
//   out_*                : registered control bundle
//   out_beat, out_last   : DRW beat index and final-beat marker
//   busy                 : sequencer is in a DRW burst
//   illegal              : sticky trap flag (only with SPU_DECODE_ILLEGAL_TRAP_EN)
//   dbg_state            : current sequencer state (state_t encoding)
// Configuration macro: SPU_DECODE_ILLEGAL_TRAP_EN
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. valid never drops and the payload never changes until the transfer,
// except that flush withdraws out_valid. in_ready may depend combinationally
// on out_ready (a slot frees only when the held beat leaves) and is held low
// during a flush cycle.
module spu_decode_stage
    import spu_decode_pkg::*;
#(
    parameter int COLOR_W   = 8,
    parameter int DRW_BEATS = 4,
    parameter int BEAT_W    = (DRW_BEATS > 1) ? $clog2(DRW_BEATS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [5:0]         in_funct,
    input  logic [3:0]         in_rd,
    input  logic [COLOR_W-1:0] in_color,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_flagw,
    output logic               out_pcs,
    output logic               out_regw,
    output logic               out_memw,
    output logic               out_regw_spu,
    output logic               out_nowrite,
    output logic               out_memtoreg,
    output logic               out_alusrc,
    output logic [1:0]         out_immsrc,
    output logic [1:0]         out_regsrc,
    output logic [3:0]         out_alucontrol,
    output logic [COLOR_W+3:0] out_spucontrol,
    output logic [BEAT_W-1:0]  out_beat,
    output logic               out_last,
    output logic               busy,
`ifdef SPU_DECODE_ILLEGAL_TRAP_EN
    output logic               illegal,
`endif
    output logic [1:0]         dbg_state
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DRW_BEATS - 1);

    state_t             state;
    ctrl_t              ctrl_q;
    logic [COLOR_W+3:0] spu_q;
    logic [BEAT_W-1:0]  beat_q;
    logic               valid_q;
    logic               last_q;

    ctrl_t              dec_ctrl;
    logic [COLOR_W+3:0] dec_spu;
    logic               dec_drw;
    logic               accept;
    logic               handshake;

`ifdef SPU_DECODE_ILLEGAL_TRAP_EN
    logic dec_illegal;
    logic illegal_q;
`endif

    spu_decode_comb #(.COLOR_W(COLOR_W)) u_comb (
        .op         (in_op),
        .funct      (in_funct),
        .rd         (in_rd),
        .color      (in_color),
`ifdef SPU_DECODE_ILLEGAL_TRAP_EN
        .illegal    (dec_illegal),
`endif
        .ctrl       (dec_ctrl),
        .spucontrol (dec_spu),
        .is_drw     (dec_drw)
    );

    // A new instruction fits only when the output slot is empty or its final
    // beat is leaving this cycle.
    always_comb begin
        in_ready = 1'b0;
        if (!flush) begin
            case (state)
                ST_IDLE:  in_ready = 1'b1;
                ST_HOLD:  in_ready = out_ready;
                ST_BURST: in_ready = out_ready & last_q;
                default:  in_ready = 1'b0;
            endcase
        end
    end

    assign accept    = in_valid & in_ready;
    assign handshake = valid_q & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ctrl_q  <= '0;
            spu_q   <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (flush) begin
            state   <= ST_IDLE;
            beat_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (accept) begin
            ctrl_q  <= dec_ctrl;
            spu_q   <= dec_spu;
            beat_q  <= '0;
            valid_q <= 1'b1;
            if (dec_drw && (DRW_BEATS > 1)) begin
                state  <= ST_BURST;
                last_q <= 1'b0;
            end else begin
                state  <= ST_HOLD;
                last_q <= 1'b1;
            end
        end else if (handshake) begin
            if ((state == ST_BURST) && !last_q) begin
                beat_q <= beat_q + BEAT_W'(1);
                last_q <= ((beat_q + BEAT_W'(1)) == LAST_BEAT);
            end else begin
                state   <= ST_IDLE;
                beat_q  <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

`ifdef SPU_DECODE_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (accept && dec_illegal) begin
            illegal_q <= 1'b1;
        end
    end
    assign illegal = illegal_q;
`endif

    assign out_valid      = valid_q;
    assign out_flagw      = ctrl_q.flagw;
    assign out_pcs        = ctrl_q.pcs;
    assign out_regw       = ctrl_q.regw;
    assign out_memw       = ctrl_q.memw;
    assign out_regw_spu   = ctrl_q.regw_spu;
    assign out_nowrite    = ctrl_q.nowrite;
    assign out_memtoreg   = ctrl_q.memtoreg;
    assign out_alusrc     = ctrl_q.alusrc;
    assign out_immsrc     = ctrl_q.immsrc;
    assign out_regsrc     = ctrl_q.regsrc;
    assign out_alucontrol = ctrl_q.alucontrol;
    assign out_spucontrol = spu_q;
    assign out_beat       = beat_q;
    assign out_last       = last_q;
    assign busy           = (state == ST_BURST);
    assign dbg_state      = state;

endmodule

// File: tb/tb_spu_decode_stage.sv
// tb_spu_decode_stage
// Randomised + directed bench for spu_decode_stage (COLOR_W=8, DRW_BEATS=4).
// Driver pushes expected beats into exp_q on accept; a negedge monitor
// compares every presented beat against the queue head.
// Configuration macro honoured: SPU_DECODE_ILLEGAL_TRAP_EN
module tb_spu_decode_stage;

    localparam int COLOR_W   = 8;
    localparam int DRW_BEATS = 4;
    localparam int BEAT_W    = 2;
    localparam int SPU_W     = COLOR_W + 4;
    localparam int W         = 19 + SPU_W + BEAT_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [1:0]         in_op = '0;
    logic [5:0]         in_funct = '0;
    logic [3:0]         in_rd = '0;
    logic [COLOR_W-1:0] in_color = '0;
    logic               flush = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [1:0]         out_flagw;
    logic               out_pcs, out_regw, out_memw, out_regw_spu;
    logic               out_nowrite, out_memtoreg, out_alusrc;
    logic [1:0]         out_immsrc, out_regsrc;
    logic [3:0]         out_alucontrol;
    logic [SPU_W-1:0]   out_spucontrol;
    logic [BEAT_W-1:0]  out_beat;
    logic               out_last;
    logic               busy;
    logic [1:0]         dbg_state;
`ifdef SPU_DECODE_ILLEGAL_TRAP_EN
    logic               illegal;
`endif

    spu_decode_stage #(.COLOR_W(COLOR_W), .DRW_BEATS(DRW_BEATS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_funct       (in_funct),
        .in_rd          (in_rd),
        .in_color       (in_color),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_flagw      (out_flagw),
        .out_pcs        (out_pcs),
        .out_regw       (out_regw),
        .out_memw       (out_memw),
        .out_regw_spu   (out_regw_spu),
        .out_nowrite    (out_nowrite),
        .out_memtoreg   (out_memtoreg),
        .out_alusrc     (out_alusrc),
        .out_immsrc     (out_immsrc),
        .out_regsrc     (out_regsrc),
        .out_alucontrol (out_alucontrol),
        .out_spucontrol (out_spucontrol),
        .out_beat       (out_beat),
        .out_last       (out_last),
        .busy           (busy),
`ifdef SPU_DECODE_ILLEGAL_TRAP_EN
        .illegal        (illegal),
`endif
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [3:0]  alu_tbl [logic [3:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] act_word();
        return {busy, out_flagw, out_pcs, out_regw, out_memw, out_regw_spu,
                out_nowrite, out_memtoreg, out_alusrc, out_immsrc, out_regsrc,
                out_alucontrol, out_spucontrol, out_beat, out_last};
    endfunction

    // ---------------- reference model ----------------
    function automatic bit ref_illegal(input logic [1:0] op, input logic [5:0] fn);
        return ((op == 2'd0) && !alu_tbl.exists(fn[4:1])) || ((op == 2'd3) && fn[0]);
    endfunction

    function automatic bit ref_drw(input logic [1:0] op, input logic [5:0] fn);
        bit d;
        d = (op == 2'd3) && ((fn[4:1] == 4'b0101) || (fn[4:1] == 4'b1100));
`ifdef SPU_DECODE_ILLEGAL_TRAP_EN
        if (ref_illegal(op, fn)) d = 1'b0;
`endif
        return d;
    endfunction

    function automatic logic [W-1:0] ref_beat(input logic [1:0] op, input logic [5:0] fn,
                                              input logic [3:0] rd, input logic [COLOR_W-1:0] col,
                                              input int beat, input bit last, input bit bsy);
        logic [3:0]       code;
        logic [1:0]       flagw, immsrc, regsrc;
        logic             pcs, regw, memw, rspu, nowr, m2r, asrc;
        logic [3:0]       aluc;
        logic [SPU_W-1:0] spu;
        logic [BEAT_W-1:0] b;
        code = fn[4:1];
        flagw = '0; immsrc = '0; regsrc = '0; aluc = '0; spu = '1;
        regw = 0; memw = 0; rspu = 0; nowr = 0; m2r = 0; asrc = 0;
        b = BEAT_W'(beat);
        if (op == 2'd0) begin
            regw = 1; asrc = fn[5];
            if (alu_tbl.exists(code)) aluc = alu_tbl[code];
            nowr = (code == 4'b1010);
            flagw = {fn[0], fn[0] && (code inside {4'b0100, 4'b0010, 4'b1010})};
        end else if (op == 2'd1) begin
            immsrc = 2'b01; asrc = 1; m2r = 1;
            regw = fn[0]; memw = !fn[0];
            regsrc = fn[0] ? 2'b00 : 2'b10;
        end else if (op == 2'd2) begin
            regsrc = 2'b01; immsrc = 2'b10; asrc = 1;
        end else begin
            spu = {code, col}; m2r = 1;
            if (code == 4'b0101 || code == 4'b1100) memw = 1;
            else begin regw = 1; rspu = 1; end
        end
        pcs = (op == 2'd2) || (rd == 4'd15 && regw);
`ifdef SPU_DECODE_ILLEGAL_TRAP_EN
        if (ref_illegal(op, fn)) begin regw = 0; memw = 0; rspu = 0; pcs = 0; end
`endif
        return {bsy, flagw, pcs, regw, memw, rspu, nowr, m2r, asrc, immsrc, regsrc, aluc, spu, b, last};
    endfunction

    task automatic push_instr(input logic [1:0] op, input logic [5:0] fn,
                              input logic [3:0] rd, input logic [COLOR_W-1:0] col);
        int n;
        bit d;
        d = ref_drw(op, fn) && (DRW_BEATS > 1);
        n = d ? DRW_BEATS : 1;
        for (int i = 0; i < n; i++)
            exp_q.push_back(ref_beat(op, fn, rd, col, i, (i == n - 1), d));
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive at posedge+1, predict in_ready at +3, record the
    // accepted instruction just after the monitor has run at the negedge.
    task automatic cycle(input bit v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [3:0] rd, input logic [COLOR_W-1:0] col,
                         input bit ordy, input bit fl, output bit acc);
        bit exp_rdy;
        @(posedge clk);
        #1;
        in_valid = v; in_op = op; in_funct = fn; in_rd = rd; in_color = col;
        out_ready = ordy; flush = fl;
        #2;
        exp_rdy = !fl && ((exp_q.size() == 0) || (exp_q.size() == 1 && ordy));
        check("in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy;
        @(negedge clk);
        #1;
        if (fl) exp_q.delete();
        if (acc) push_instr(op, fn, rd, col);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && mon_en && !flush) begin
            check("out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                check("bundle", act_word(), exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
            if (!out_valid) check("busy_idle", busy, 1'b0);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        bit acc;
        int n;
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] rd;

        alu_tbl[4'b0000] = 4'b0010; alu_tbl[4'b0001] = 4'b0100;
        alu_tbl[4'b0010] = 4'b0001; alu_tbl[4'b0100] = 4'b0000;
        alu_tbl[4'b1000] = 4'b1000; alu_tbl[4'b1001] = 4'b1001;
        alu_tbl[4'b1010] = 4'b0001; alu_tbl[4'b1100] = 4'b0011;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bundle", act_word(), '0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_state", dbg_state, 2'd0);
`ifdef SPU_DECODE_ILLEGAL_TRAP_EN
        check("rst_illegal", illegal, 1'b0);
`endif
        @(posedge clk); #1; rst_n = 1'b1; mon_en = 1'b1;

        // ADD imm S=1, CMP, STR back-to-back under continuous ready
        cycle(1, 2'd0, 6'b101001, 4'd3, 8'h00, 1, 0, acc);
        cycle(1, 2'd0, 6'b010101, 4'd4, 8'h00, 1, 0, acc);
        cycle(1, 2'd1, 6'b000000, 4'd5, 8'h00, 1, 0, acc);
        cycle(0, 2'd0, 6'b000000, 4'd0, 8'h00, 1, 0, acc);
        cycle(0, 2'd0, 6'b000000, 4'd0, 8'h00, 1, 0, acc);

        // DRW burst; the following ADD waits until the last beat leaves
        cycle(1, 2'd3, 6'b001010, 4'd2, 8'hA5, 1, 0, acc);
        n = 0; acc = 0;
        while (!acc && n < 10) begin
            cycle(1, 2'd0, 6'b001000, 4'd6, 8'h00, 1, 0, acc);
            n++;
        end
        check("drw_accept_gap", n, DRW_BEATS);

        // branch held under 3 stalled cycles
        cycle(1, 2'd2, 6'b000000, 4'd0, 8'h00, 1, 0, acc);
        repeat (3) cycle(1, 2'd0, 6'b001000, 4'd1, 8'h00, 0, 0, acc);
        repeat (3) cycle(0, 2'd0, 6'b000000, 4'd0, 8'h00, 1, 0, acc);

        // flush on beat 1 of a DRW with an incoming instruction
        cycle(1, 2'd3, 6'b011000, 4'd7, 8'h3C, 1, 0, acc);
        cycle(0, 2'd0, 6'b000000, 4'd0, 8'h00, 1, 0, acc);
        cycle(1, 2'd0, 6'b001000, 4'd8, 8'h00, 1, 1, acc);
        cycle(0, 2'd0, 6'b000000, 4'd0, 8'h00, 1, 0, acc);
        check("flush_state", dbg_state, 2'd0);
        check("flush_valid", out_valid, 1'b0);

        // asynchronous reset in the middle of a burst
        cycle(1, 2'd3, 6'b001010, 4'd9, 8'h11, 1, 0, acc);
        cycle(0, 2'd0, 6'b000000, 4'd0, 8'h00, 1, 0, acc);
        #1;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_beat", out_beat, '0);
        check("arst_state", dbg_state, 2'd0);
        exp_q.delete();
        @(posedge clk); #1; rst_n = 1'b1; mon_en = 1'b1;

`ifdef SPU_DECODE_ILLEGAL_TRAP_EN
        check("illegal_clear", illegal, 1'b0);
        cycle(1, 2'd3, 6'b000001, 4'd1, 8'h00, 1, 0, acc);
        cycle(1, 2'd0, 6'b001000, 4'd2, 8'h00, 1, 0, acc);
        cycle(0, 2'd0, 6'b000000, 4'd0, 8'h00, 1, 0, acc);
        check("illegal_sticky", illegal, 1'b1);
`endif

        // randomised traffic with backpressure and occasional flushes
        for (int i = 0; i < 400; i++) begin
            op = 2'($urandom_range(0, 3));
            fn = 6'($urandom_range(0, 63));
            if (op == 2'd3 && $urandom_range(0, 2) == 0)
                fn[4:1] = ($urandom_range(0, 1) == 0) ? 4'b0101 : 4'b1100;
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 3) != 0, op, fn, rd, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, acc);
        end

        // drain
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cycle(0, 2'd0, 6'b000000, 4'd0, 8'h00, 1, 0, acc);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
`ifdef SPU_DECODE_ILLEGAL_TRAP_EN
        check("illegal_end", illegal, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
